// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scan of an N-digit common-anode 7-segment bank.
// The prescaler paces the digit slots. The shadow digits only change at frame
// boundaries, so a displayed frame never mixes old and new digits. The outputs
// are registered and follow the digit index one cycle late.
module display_scan_ctrl #(
  parameter int N_DIG    = 4,
  parameter int PRESCALE = 50000,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [4*N_DIG-1:0]   bcd_in,
  input  logic                 load,
  input  logic                 blank_lz,
  output logic                 load_ack,
  output logic [3:0]           digito,
  output logic [N_DIG-1:0]     an,
  output logic                 blank,
  output logic                 frame_done
);

  localparam int IDX_W = (N_DIG > 2) ? $clog2(N_DIG) : 1;
  localparam logic [CNT_W-1:0] PS_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);

  logic [CNT_W-1:0]   prescaler_q, prescaler_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [4*N_DIG-1:0] shadow_q, shadow_d;
  logic [4*N_DIG-1:0] staged_q, staged_d;
  logic               pend_q, pend_d;
  logic [N_DIG-1:0]   an_q, an_d;
  logic [3:0]         digito_q, digito_d;
  logic               blank_q, blank_d;
  logic               load_ack_q, load_ack_d;
  logic               frame_done_q, frame_done_d;

  logic               tick;
  logic               boundary;
  logic [3:0]         cur_dig;
  logic               upper_zero;

  // Pick the active digit, and check whether it and every more-significant digit are zero.
  always_comb begin
    cur_dig    = 4'd0;
    upper_zero = 1'b1;
    for (int k = 0; k < N_DIG; k++) begin
      if (idx_q == IDX_W'(k)) cur_dig = shadow_q[4*k +: 4];
      if (IDX_W'(k) >= idx_q && shadow_q[4*k +: 4] != 4'd0) upper_zero = 1'b0;
    end
  end

  // Compute the next state for the prescaler, the index, the load handshake and the output stage.
  always_comb begin
    tick         = enable && (prescaler_q == PS_LAST);
    boundary     = tick && (idx_q == IDX_LAST);

    prescaler_d  = prescaler_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    staged_d     = staged_q;
    pend_d       = pend_q;
    load_ack_d   = 1'b0;
    frame_done_d = boundary;

    if (enable) begin
      prescaler_d = (prescaler_q == PS_LAST) ? '0 : prescaler_q + 1'b1;
    end
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // A load in the boundary cycle goes straight to the shadow, so it takes no extra frame.
    if (boundary && (pend_q || load)) begin
      shadow_d   = load ? bcd_in : staged_q;
      pend_d     = 1'b0;
      load_ack_d = 1'b1;
    end else if (load) begin
      staged_d = bcd_in;
      pend_d   = 1'b1;
    end

    an_d     = enable ? ~(N_DIG'(1) << idx_q) : '1;
    digito_d = cur_dig;
    blank_d  = !enable || (cur_dig > 4'd9) ||
               (blank_lz && (idx_q != '0) && upper_zero);
  end

  // Register all state, with a synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_q  <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      staged_q     <= '0;
      pend_q       <= 1'b0;
      an_q         <= '1;
      digito_q     <= 4'd0;
      blank_q      <= 1'b1;
      load_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      staged_q     <= staged_d;
      pend_q       <= pend_d;
      an_q         <= an_d;
      digito_q     <= digito_d;
      blank_q      <= blank_d;
      load_ack_q   <= load_ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign digito     = digito_q;
  assign blank      = blank_q;
  assign load_ack   = load_ack_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed first-frame latency plus a randomized run
// against a slot/frame reference model.
module tb_display_scan_ctrl;

  localparam int N = 4;
  localparam int P = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [4*N-1:0]   bcd_in;
  logic             load;
  logic             blank_lz;
  logic             load_ack;
  logic [3:0]       digito;
  logic [N-1:0]     an;
  logic             blank;
  logic             frame_done;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: position within the slot, active digit, displayed and staged values.
  int m_cnt, m_pos, m_shadow, m_staged;
  bit m_pend;

  always #5 clk = ~clk;

  display_scan_ctrl #(.N_DIG(N), .PRESCALE(P), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bcd_in(bcd_in),
    .load(load), .blank_lz(blank_lz), .load_ack(load_ack),
    .digito(digito), .an(an), .blank(blank), .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int digit_of(int v, int k);
    return (v >> (4*k)) & 15;
  endfunction

  // One clock: predict the outputs from the model, advance the model, clock the DUT, compare.
  task automatic step();
    int e_an, e_dig, e_blank, e_ack, e_fd;
    bit tick, bnd, zeros;
    if (reset) begin
      m_cnt = 0; m_pos = 0; m_shadow = 0; m_staged = 0; m_pend = 0;
      e_an = (1 << N) - 1; e_dig = 0; e_blank = 1; e_ack = 0; e_fd = 0;
    end else begin
      e_dig = digit_of(m_shadow, m_pos);
      zeros = 1;
      for (int j = m_pos; j < N; j++) if (digit_of(m_shadow, j) != 0) zeros = 0;
      e_an    = enable ? (((1 << N) - 1) ^ (1 << m_pos)) : ((1 << N) - 1);
      e_blank = (!enable || e_dig > 9 || (blank_lz && m_pos != 0 && zeros)) ? 1 : 0;
      tick    = enable && (m_cnt == P - 1);
      bnd     = tick && (m_pos == N - 1);
      e_fd    = bnd ? 1 : 0;
      e_ack   = 0;
      if (bnd && (m_pend || load)) begin
        m_shadow = load ? int'(bcd_in) : m_staged;
        m_pend   = 0;
        e_ack    = 1;
      end else if (load) begin
        m_staged = int'(bcd_in);
        m_pend   = 1;
      end
      if (enable) m_cnt = (m_cnt + 1) % P;
      if (tick)   m_pos = (m_pos + 1) % N;
    end
    @(posedge clk);
    #1;
    chk("an",         32'(an),         32'(e_an));
    chk("digito",     32'(digito),     32'(e_dig));
    chk("blank",      32'(blank),      32'(e_blank));
    chk("load_ack",   32'(load_ack),   32'(e_ack));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
  endtask

  // Digits are biased toward zeros (to exercise blanking) and an occasional invalid code.
  function automatic logic [4*N-1:0] rand_bcd();
    logic [4*N-1:0] v;
    int r;
    v = '0;
    for (int k = 0; k < N; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       v[4*k +: 4] = 4'd0;
      else if (r == 4) v[4*k +: 4] = 4'($urandom_range(10, 15));
      else             v[4*k +: 4] = 4'($urandom_range(1, 9));
    end
    return v;
  endfunction

  initial begin
    int ack_at;
    reset = 1'b1; enable = 1'b0; bcd_in = '0; load = 1'b0; blank_lz = 1'b0;
    step();
    step();

    // First load is committed at the end of the first full frame after enable.
    reset  = 1'b0;
    enable = 1'b1;
    load   = 1'b1;
    bcd_in = 16'h4321;
    ack_at = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      load = 1'b0;
      if (load_ack === 1'b1 && ack_at < 0) ack_at = k;
    end
    chk("ack_latency", 32'(ack_at), 32'd16);

    // Randomized run with enable gaps, loads, blanking changes and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      reset    = ($urandom_range(0, 499) == 0);
      enable   = ($urandom_range(0, 15) != 0);
      load     = ($urandom_range(0, 11) == 0);
      bcd_in   = rand_bcd();
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
